// File: rtl/rv32_pkg.sv
// Shared RV32I constants and register-index types.
package rv32_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   typedef logic [REG_AW-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit vector tracking in-flight register writes. Issue marks a register
// busy and writeback clears it. A mark and a clear landing on the same
// register in one cycle leave it busy, because the newer producer still owes
// a value. Bit 0 is never busy.
module regfile_scoreboard
   import rv32_pkg::*;
#(
   parameter int NREGS = rv32_pkg::NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mark_en,
   input  logic [AW-1:0]    mark_addr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   output logic [NREGS-1:0] busy,
   output logic             any_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Next busy vector: set by mark, cleared by write, mark has priority.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         if (mark_en && (mark_addr == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (wr_en && (wr_addr == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Busy-bit register; reset forces every bit idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign any_busy = |busy_q[NREGS-1:1];

endmodule

// File: rtl/regfile_bp.sv
// RV32I integer register file with registered, individually enabled read
// ports, same-cycle write-to-read bypass and an in-flight write scoreboard.
module regfile_bp
   import rv32_pkg::*;
#(
   parameter int XLEN  = rv32_pkg::XLEN,
   parameter int NREGS = rv32_pkg::NREGS,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NRD-1:0]    rd_en,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]    rd_busy,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              mark_en,
   input  logic [AW-1:0]     mark_addr,
   output logic              any_busy
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic [XLEN-1:0]  mem_q [NREGS];
   logic [NREGS-1:0] busy;

   // Register array; entry 0 is never written so it reads as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            mem_q[r] <= '0;
         end
      end else if (wr_en && (wr_addr != ZERO_IDX)) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .busy      (busy),
      .any_busy  (any_busy)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            wr_hit;
      logic [XLEN-1:0] rdata_d;
      logic [XLEN-1:0] rdata_q;

      assign addr   = rd_addr[i*AW +: AW];
      assign wr_hit = wr_en && (wr_addr == addr);

      // Port data select: x0 reads zero, a same-cycle write is forwarded,
      // and a disabled port holds its last value for stalls.
      always_comb begin
         rdata_d = rdata_q;
         if (rd_en[i]) begin
            if (addr == ZERO_IDX) begin
               rdata_d = '0;
            end else if (wr_hit) begin
               rdata_d = wr_data;
            end else begin
               rdata_d = mem_q[addr];
            end
         end
      end

      // Registered read data.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= rdata_d;
         end
      end

      assign rdata[i*XLEN +: XLEN] = rdata_q;
      // A write retiring this cycle is bypassed, so it does not stall decode.
      assign rd_busy[i] = busy[addr] & ~wr_hit;
   end

endmodule

// File: tb/tb_regfile_bp.sv
// Self-checking bench for regfile_bp: directed vector table, randomised
// traffic against a behavioural model, and an asynchronous reset sequence.
module tb_regfile_bp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic              clk;
   logic              reset;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]    rd_busy;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic              mark_en;
   logic [AW-1:0]     mark_addr;
   logic              any_busy;

   regfile_bp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rdata     (rdata),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .any_busy  (any_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  rd_en;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        mk;
      logic [4:0]  ma;
   } vin_t;

   typedef struct packed {
      vin_t        in;
      logic [1:0]  e_busy;
      logic        e_any;
      logic [31:0] e_r0;
      logic [31:0] e_r1;
   } vec_t;

   typedef struct packed {
      logic [31:0] r0;
      logic [31:0] r1;
   } rexp_t;

   rexp_t exp_q[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   // behavioural model
   logic [31:0] mem_m   [NREGS];
   logic        busy_m  [NREGS];
   logic [31:0] rdata_m [NRD];

   function automatic vec_t mkv(logic [1:0] re, logic [4:0] a0, logic [4:0] a1,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic mk, logic [4:0] ma, logic [1:0] eb,
                                logic ea, logic [31:0] r0, logic [31:0] r1);
      vec_t v;
      v.in.rd_en = re; v.in.a0 = a0; v.in.a1 = a1;
      v.in.we = we; v.in.wa = wa; v.in.wd = wd;
      v.in.mk = mk; v.in.ma = ma;
      v.e_busy = eb; v.e_any = ea; v.e_r0 = r0; v.e_r1 = r1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         mem_m[r]  = '0;
         busy_m[r] = 1'b0;
      end
      for (int p = 0; p < NRD; p++) rdata_m[p] = '0;
   endtask

   function automatic logic [31:0] model_read(input vin_t v, input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (v.we && v.wa == a) return v.wd;
      return mem_m[a];
   endfunction

   function automatic logic model_rd_busy(input vin_t v, input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      return busy_m[a] && !(v.we && v.wa == a);
   endfunction

   function automatic logic model_any();
      logic b = 1'b0;
      for (int r = 1; r < NREGS; r++) b = b | busy_m[r];
      return b;
   endfunction

   // expectation for a vector purely from the model state
   function automatic vec_t model_vec(input vin_t v);
      vec_t e;
      e.in = v;
      e.e_busy = {model_rd_busy(v, v.a1), model_rd_busy(v, v.a0)};
      e.e_any  = model_any();
      e.e_r0   = v.rd_en[0] ? model_read(v, v.a0) : rdata_m[0];
      e.e_r1   = v.rd_en[1] ? model_read(v, v.a1) : rdata_m[1];
      return e;
   endfunction

   task automatic model_commit(input vin_t v);
      if (v.rd_en[0]) rdata_m[0] = model_read(v, v.a0);
      if (v.rd_en[1]) rdata_m[1] = model_read(v, v.a1);
      for (int r = 1; r < NREGS; r++) begin
         if (v.mk && v.ma == 5'(r)) busy_m[r] = 1'b1;
         else if (v.we && v.wa == 5'(r)) busy_m[r] = 1'b0;
      end
      if (v.we && v.wa != 5'd0) mem_m[v.wa] = v.wd;
   endtask

   task automatic drive(input vin_t v);
      rd_en     = v.rd_en;
      rd_addr   = {v.a1, v.a0};
      wr_en     = v.we;
      wr_addr   = v.wa;
      wr_data   = v.wd;
      mark_en   = v.mk;
      mark_addr = v.ma;
   endtask

   // One clock: drive at negedge, check combinational outputs, then check
   // registered read data just after the rising edge.
   task automatic step(input vec_t e);
      rexp_t r;
      @(negedge clk);
      drive(e.in);
      exp_q.push_back({e.e_r0, e.e_r1});
      #1;
      check("rd_busy", 32'(rd_busy), 32'(e.e_busy));
      check("any_busy", 32'(any_busy), 32'(e.e_any));
      model_commit(e.in);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         r = exp_q.pop_front();
         check("rdata0", rdata[31:0], r.r0);
         check("rdata1", rdata[63:32], r.r1);
      end
   endtask

   vec_t tbl[19];
   vin_t idle;
   vin_t rv;

   initial begin
      idle = '0;
      drive(idle);
      reset = 1'b1;
      model_reset();

      // directed vectors: rd_en, a0, a1, we, wa, wd, mk, ma | rd_busy, any, r0, r1
      // x0 write discarded, x0 reads zero, x0 mark ignored
      tbl[0]  = mkv(2'b00, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 2'b00, 0, 32'h0, 32'h0);
      tbl[1]  = mkv(2'b11, 0, 0, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'h0, 32'h0);
      tbl[2]  = mkv(2'b11, 0, 0, 0, 0, 32'h0,        1, 0, 2'b00, 0, 32'h0, 32'h0);
      tbl[3]  = mkv(2'b11, 0, 0, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'h0, 32'h0);
      // bypass x7, then array read on port 1
      tbl[4]  = mkv(2'b01, 7, 0, 1, 7, 32'h12345678, 0, 0, 2'b00, 0, 32'h12345678, 32'h0);
      tbl[5]  = mkv(2'b10, 0, 7, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'h12345678, 32'h12345678);
      // hold on port 1 while x3 changes
      tbl[6]  = mkv(2'b00, 0, 0, 1, 3, 32'hA5A5A5A5, 0, 0, 2'b00, 0, 32'h12345678, 32'h12345678);
      tbl[7]  = mkv(2'b10, 0, 3, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'h12345678, 32'hA5A5A5A5);
      tbl[8]  = mkv(2'b00, 0, 7, 1, 3, 32'h00000001, 0, 0, 2'b00, 0, 32'h12345678, 32'hA5A5A5A5);
      tbl[9]  = mkv(2'b01, 3, 5, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'h00000001, 32'hA5A5A5A5);
      // scoreboard mark/clear of x9
      tbl[10] = mkv(2'b00, 9, 9, 0, 0, 32'h0,        1, 9, 2'b00, 0, 32'h00000001, 32'hA5A5A5A5);
      tbl[11] = mkv(2'b00, 9, 3, 0, 0, 32'h0,        0, 0, 2'b01, 1, 32'h00000001, 32'hA5A5A5A5);
      tbl[12] = mkv(2'b01, 9, 9, 1, 9, 32'hCAFEF00D, 0, 0, 2'b00, 1, 32'hCAFEF00D, 32'hA5A5A5A5);
      tbl[13] = mkv(2'b00, 9, 9, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'hCAFEF00D, 32'hA5A5A5A5);
      // mark/write collision on x4
      tbl[14] = mkv(2'b00, 4, 4, 0, 0, 32'h0,        1, 4, 2'b00, 0, 32'hCAFEF00D, 32'hA5A5A5A5);
      tbl[15] = mkv(2'b00, 4, 4, 1, 4, 32'h55AA55AA, 1, 4, 2'b00, 1, 32'hCAFEF00D, 32'hA5A5A5A5);
      tbl[16] = mkv(2'b10, 4, 4, 0, 0, 32'h0,        0, 0, 2'b11, 1, 32'hCAFEF00D, 32'h55AA55AA);
      tbl[17] = mkv(2'b00, 4, 4, 1, 4, 32'h00000077, 0, 0, 2'b00, 1, 32'hCAFEF00D, 32'h55AA55AA);
      tbl[18] = mkv(2'b00, 4, 4, 0, 0, 32'h0,        0, 0, 2'b00, 0, 32'hCAFEF00D, 32'h55AA55AA);

      // reset state
      #12;
      check("reset_rdata0", rdata[31:0], 32'h0);
      check("reset_rdata1", rdata[63:32], 32'h0);
      check("reset_any_busy", 32'(any_busy), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) step(tbl[i]);

      // random traffic on a small address window to provoke collisions
      for (int i = 0; i < 200; i++) begin
         rv.rd_en = 2'($urandom_range(0, 3));
         rv.a0    = 5'($urandom_range(0, 7));
         rv.a1    = 5'($urandom_range(0, 7));
         rv.we    = 1'($urandom_range(0, 1));
         rv.wa    = 5'($urandom_range(0, 7));
         rv.wd    = $urandom;
         rv.mk    = ($urandom_range(0, 3) == 0);
         rv.ma    = 5'($urandom_range(0, 7));
         step(model_vec(rv));
      end

      // asynchronous reset mid-cycle with a write and mark in flight
      rv = '0;
      rv.rd_en = 2'b11; rv.a0 = 5; rv.a1 = 5;
      rv.we = 1; rv.wa = 5; rv.wd = 32'hDEADBEEF;
      rv.mk = 1; rv.ma = 6;
      step(model_vec(rv));
      check("pre_reset_rdata0", rdata[31:0], 32'hDEADBEEF);
      #2;
      rd_en = 2'b11; rd_addr = {5'd6, 5'd6};
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h01234567;
      mark_en = 1'b1; mark_addr = 5'd5;
      reset = 1'b1;
      #1;
      check("async_reset_rdata0", rdata[31:0], 32'h0);
      check("async_reset_rdata1", rdata[63:32], 32'h0);
      check("async_reset_rd_busy", 32'(rd_busy), 32'h0);
      check("async_reset_any_busy", 32'(any_busy), 32'h0);
      @(posedge clk);
      #1;
      check("reset_held_rdata0", rdata[31:0], 32'h0);
      check("reset_held_any_busy", 32'(any_busy), 32'h0);
      @(negedge clk);
      drive(idle);
      reset = 1'b0;
      model_reset();
      exp_q.delete();

      rv = '0;
      rv.rd_en = 2'b11; rv.a0 = 5; rv.a1 = 6;
      step(mkv(rv.rd_en, rv.a0, rv.a1, 0, 0, 32'h0, 0, 0, 2'b00, 0, 32'h0, 32'h0));
      check("post_reset_any_busy", 32'(any_busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
      $fatal(1);
   end

endmodule
